uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte transmit queue sitting directly upstream of the serial-port UART wrapper. It accepts bytes from the CPU/bus side into a small FIFO and drains them one at a time into the UART. It drives the UART's `data_in` and active-low write strobe `wrn`, and honours the UART's `tbre`/`tsre` ready flags, so producers never have to poll the serial status themselves.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `AW`, default 4: log2(DEPTH).
- `WR_PULSE`, default 2: cycles `wrn` is held low per byte, ≥1.
- `GUARD`, default 2: cycles after `wrn` rises before `tbre`/`tsre` are sampled again, ≥1.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `push` in 1: write `push_data` into the FIFO this cycle.
- `push_data` in 8: byte to enqueue.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out AW+1: current FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a push was dropped.
- `tbre` in 1: UART transmit buffer empty.
- `tsre` in 1: UART transmit shift register empty.
- `data_out` out 8: byte presented to UART `data_in`.
- `wrn` out 1: active-low write strobe to UART.
- `busy` out 1: high in every FSM state except IDLE.
- `flush` in 1: present only with `UART_TX_FLUSH_EN`.

## Operation
- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo DEPTH. `count` is registered.
  - Push is accepted iff `push` is high and `full` is low, with `full` evaluated from the registered count before any same-cycle pop.
  - A push while full is dropped and sets `overflow`. `overflow` clears only on reset.
  - Push and pop in the same cycle: both occur, `count` is unchanged.
- FSM states and transitions:
  - IDLE → SETUP when `!empty && tbre && tsre`. On this transition, pop the head into the `data_out` register.
  - SETUP (1 cycle): `wrn`=1, `data_out` stable → STROBE.
  - STROBE (WR_PULSE cycles, counter-timed): `wrn`=0 → RELEASE.
  - RELEASE (GUARD cycles): `wrn`=1, UART flags ignored → DRAIN.
  - DRAIN: wait until `tbre && tsre` → IDLE.
- `data_out` holds the last transmitted byte until the next pop; it never changes in SETUP, STROBE or RELEASE.
- `wrn` is a registered output and is glitch-free.
- Reset values: `wrn`=1, `data_out`=0x00, `busy`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, pointers=0, FSM=IDLE.
- Reset mid-transfer aborts immediately: `wrn` returns to 1 on the next edge and queued bytes are discarded.

## Timing
- A push is visible in `count`/`empty` one cycle after its edge.
- Latency from a push into an empty FIFO, with the UART ready, to the `wrn` falling edge is 3 cycles: pushed (1), IDLE pop (2), SETUP (3), STROBE drives `wrn` low.
- Minimum byte-to-byte spacing is 1 + 1 + WR_PULSE + GUARD + 1 cycles, with DRAIN exiting on its first cycle. Default: 7 cycles.
- `tbre`/`tsre` are assumed synchronous to `clk` and are sampled only in IDLE and DRAIN.

## Configuration
- `UART_TX_FLUSH_EN` defined: adds the `flush` input.
  - While `flush`=1 on a clock edge, pointers and `count` go to 0 and any same-cycle push is ignored.
  - An in-flight byte (SETUP through DRAIN) completes normally. `overflow` is unaffected.
- Not defined: no `flush` port; the FIFO empties only by draining or by reset.

## Test plan
- Reset with `push`=1 and `push_data`=0xA5 → after release, `wrn`=1, `count`=0, `empty`=1, `overflow`=0; nothing transmitted.
- Push 0x41 with `tbre`=`tsre`=1 → `wrn` low exactly 2 cycles starting 3 cycles after the push; `data_out`=0x41 throughout; `count` returns to 0.
- Push 0x01..0x03 back-to-back; model drops `tbre` 1 cycle after `wrn` rises and restores it 20 cycles later → three strobes in order 0x01, 0x02, 0x03, each waiting for `tbre&&tsre`.
- Hold `tsre`=0 and push 17 bytes → `full`=1 after 16; the 17th is dropped; `overflow`=1 and stays 1 after the FIFO drains.
- Reset asserted during STROBE → `wrn`=1 the next cycle, `busy`=0, `count`=0.
- With `UART_TX_FLUSH_EN`: queue 5 bytes, pulse `flush` while the first is in STROBE → the first byte completes, `count`=0, no further strobes.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: producer push side plus UART data/strobe/flag side of the
// transmit queue. The optional flush line exists only when UART_TX_FLUSH_EN is
// defined.
interface uart_tx_queue_if #(
  parameter int AW = 4
);
  logic          push;
  logic [7:0]    push_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tbre;
  logic          tsre;
  logic [7:0]    data_out;
  logic          wrn;
  logic          busy;
`ifdef UART_TX_FLUSH_EN
  logic          flush;

  modport master (
    output push, push_data, tbre, tsre, flush,
    input  full, empty, count, overflow, data_out, wrn, busy
  );
  modport slave (
    input  push, push_data, tbre, tsre, flush,
    output full, empty, count, overflow, data_out, wrn, busy
  );
`else
  modport master (
    output push, push_data, tbre, tsre,
    input  full, empty, count, overflow, data_out, wrn, busy
  );
  modport slave (
    input  push, push_data, tbre, tsre,
    output full, empty, count, overflow, data_out, wrn, busy
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: small byte FIFO that drains one byte at a time into a UART,
// driving data_in / active-low wrn and honouring tbre/tsre.
// Define UART_TX_FLUSH_EN to add the flush input (clears queued bytes; an
// in-flight byte still completes).
module uart_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WR_PULSE = 2,
  parameter int GUARD    = 2
) (
  input logic          clk,
  input logic          rst,
  uart_tx_queue_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, DRAIN} state_t;

  localparam int CW = 16;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic            overflow;
  logic            wrn;
  logic [7:0]      data_out;
  logic            full, empty, push_ok, pop, flush_now, uart_rdy;

`ifdef UART_TX_FLUSH_EN
  assign flush_now = bus.flush;
`else
  assign flush_now = 1'b0;
`endif

  // full/empty come from the registered count, so a same-cycle pop never
  // makes room for a push
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = bus.push && !full && !flush_now;
  assign uart_rdy = bus.tbre && bus.tsre;

  // FIFO storage; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.push_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_now) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (bus.push && full) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FSM state and phase counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next-state: the UART flags matter only in IDLE and DRAIN; a flushing
  // cycle never pops so the cleared queue really sends nothing
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && uart_rdy && !flush_now) begin
          pop      = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = '0;
      end
      STROBE: begin
        if (cnt == CW'(WR_PULSE - 1)) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == CW'(GUARD - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (uart_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // registered UART outputs: wrn from next state so it is a clean flop output,
  // data_out only changes on a pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrn      <= 1'b1;
      data_out <= 8'h00;
    end else begin
      wrn <= (state_nx != STROBE);
      if (pop) data_out <= mem[rd_ptr];
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.data_out = data_out;
  assign bus.wrn      = wrn;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed scenarios for the UART transmit queue; a monitor
// logs every wrn falling edge and a small UART model can hold off tbre.
module tb_uart_tx_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic tbre_drv = 1'b1, tsre_drv = 1'b1;
  logic model_tbre = 1'b1, model_en = 1'b0;
  logic drop_arm = 1'b0, wrn_q = 1'b1;
  int   hold_cnt = 0;
  int   cyc = 0;
  logic [7:0] fall_data[$];
  int         fall_cyc[$];

  uart_tx_queue_if #(.AW(4)) bus();

  uart_tx_queue #(.DEPTH(16), .AW(4), .WR_PULSE(2), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.tbre = tbre_drv & model_tbre;
  assign bus.tsre = tsre_drv;

  always #5 clk = ~clk;

  // monitor + UART model: log strobe starts; when enabled, drop tbre one cycle
  // after wrn rises and restore it 20 cycles later
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (wrn_q && !bus.wrn) begin
      fall_data.push_back(bus.data_out);
      fall_cyc.push_back(cyc);
    end
    if (!model_en) begin
      model_tbre = 1'b1; hold_cnt = 0; drop_arm = 1'b0;
    end else begin
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) model_tbre = 1'b1;
      end else if (drop_arm) begin
        model_tbre = 1'b0; hold_cnt = 20; drop_arm = 1'b0;
      end
      if (!wrn_q && bus.wrn) drop_arm = 1'b1;
    end
    wrn_q = bus.wrn;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    int base;
    logic low_seen;
    rst = 1'b0; bus.push = 1'b1; bus.push_data = 8'hA5;
    step(3);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_count_in_reset got %0d want 0", bus.count); end
    rst = 1'b1; bus.push = 1'b0;
    base = fall_data.size();
    step(1);
    checks++; if (bus.wrn !== 1'b1) begin errors++; $display("FAIL rst_wrn got %b want 1", bus.wrn); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b want 1 0", bus.empty, bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.busy !== 1'b0 || bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_busy_data got busy=%b data=%h want 0 00", bus.busy, bus.data_out); end
    low_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (bus.wrn !== 1'b1) low_seen = 1'b1; end
    checks++; if (low_seen || fall_data.size() != base) begin errors++; $display("FAIL rst_no_tx got strobes=%0d want 0", fall_data.size() - base); end
  endtask

  task automatic test_single;
    logic [9:0] wrn_v, busy_v;
    logic dout_ok;
    bus.push = 1'b1; bus.push_data = 8'h41;
    step(1);
    bus.push = 1'b0;
    dout_ok = 1'b1;
    checks++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL single_count1 got count=%0d empty=%b want 1 0", bus.count, bus.empty); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step(1);
      wrn_v[i]  = bus.wrn;
      busy_v[i] = bus.busy;
      if (i == 1 && bus.count !== 5'd0) dout_ok = 1'b0;
      if (i >= 1 && bus.data_out !== 8'h41) dout_ok = 1'b0;
    end
    checks++; if (wrn_v !== 10'b11_1111_0011) begin errors++; $display("FAIL single_wrn got %b want %b", wrn_v, 10'b11_1111_0011); end
    checks++; if (busy_v !== 10'b00_0111_1110) begin errors++; $display("FAIL single_busy got %b want %b", busy_v, 10'b00_0111_1110); end
    checks++; if (!dout_ok) begin errors++; $display("FAIL single_data got data=%h count=%0d want 41 0", bus.data_out, bus.count); end
  endtask

  task automatic test_back_to_back;
    int base, t;
    base = fall_data.size();
    model_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.push = 1'b1; bus.push_data = 8'(i);
      step(1);
    end
    bus.push = 1'b0;
    t = 0;
    while (fall_data.size() < base + 3 && t < 300) begin step(1); t++; end
    checks++; if (fall_data.size() != base + 3) begin errors++; $display("FAIL b2b_strobes got %0d want 3", fall_data.size() - base); end
    step(30);
    model_en = 1'b0;
    step(2);
    if (fall_data.size() >= base + 3) begin
      checks++; if (fall_data[base] !== 8'h01 || fall_data[base+1] !== 8'h02 || fall_data[base+2] !== 8'h03) begin
        errors++; $display("FAIL b2b_order got %h %h %h want 01 02 03", fall_data[base], fall_data[base+1], fall_data[base+2]);
      end
      checks++; if (fall_cyc[base+1] - fall_cyc[base] != 26) begin errors++; $display("FAIL b2b_gap1 got %0d want 26", fall_cyc[base+1] - fall_cyc[base]); end
      checks++; if (fall_cyc[base+2] - fall_cyc[base+1] != 26) begin errors++; $display("FAIL b2b_gap2 got %0d want 26", fall_cyc[base+2] - fall_cyc[base+1]); end
    end
    checks++; if (bus.busy !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL b2b_idle got busy=%b count=%0d want 0 0", bus.busy, bus.count); end
  endtask

  task automatic test_overflow;
    int base, t;
    base = fall_data.size();
    tsre_drv = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.push = 1'b1; bus.push_data = 8'(8'h10 + i);
      step(1);
      if (i == 14) begin
        checks++; if (bus.full !== 1'b0 || bus.count !== 5'd15) begin errors++; $display("FAIL ovf_15 got full=%b count=%0d want 0 15", bus.full, bus.count); end
      end
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_16 got full=%b count=%0d ovf=%b want 1 16 0", bus.full, bus.count, bus.overflow);
        end
      end
    end
    bus.push = 1'b0;
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL ovf_17 got ovf=%b count=%0d want 1 16", bus.overflow, bus.count); end
    checks++; if (fall_data.size() != base || bus.wrn !== 1'b1) begin errors++; $display("FAIL ovf_hold got strobes=%0d wrn=%b want 0 1", fall_data.size() - base, bus.wrn); end
    tsre_drv = 1'b1;
    t = 0;
    step(1);
    while (!(bus.empty === 1'b1 && bus.busy === 1'b0) && t < 300) begin step(1); t++; end
    checks++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_drain_timeout got empty=%b busy=%b want 1 0", bus.empty, bus.busy); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    checks++; if (fall_data.size() != base + 16) begin errors++; $display("FAIL ovf_sent got %0d want 16", fall_data.size() - base); end
    if (fall_data.size() == base + 16) begin
      checks++; if (fall_data[base] !== 8'h10 || fall_data[base+15] !== 8'h1F) begin
        errors++; $display("FAIL ovf_bytes got first=%h last=%h want 10 1f", fall_data[base], fall_data[base+15]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t, n;
    bus.push = 1'b1; bus.push_data = 8'h55; step(1);
    bus.push_data = 8'h66; step(1);
    bus.push = 1'b0;
    t = 0;
    while (bus.wrn !== 1'b0 && t < 20) begin step(1); t++; end
    checks++; if (bus.wrn !== 1'b0) begin errors++; $display("FAIL mid_strobe_timeout got wrn=%b want 0", bus.wrn); end
    rst = 1'b0;
    step(1);
    checks++; if (bus.wrn !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_abort got wrn=%b busy=%b want 1 0", bus.wrn, bus.busy); end
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL mid_clear got count=%0d empty=%b ovf=%b want 0 1 0", bus.count, bus.empty, bus.overflow);
    end
    rst = 1'b1;
    n = fall_data.size();
    step(20);
    checks++; if (fall_data.size() != n) begin errors++; $display("FAIL mid_discard got strobes=%0d want 0", fall_data.size() - n); end
  endtask

`ifdef UART_TX_FLUSH_EN
  task automatic test_flush;
    int base, t;
    base = fall_data.size();
    tsre_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.push = 1'b1; bus.push_data = 8'(8'h61 + i);
      step(1);
    end
    bus.push = 1'b0;
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL flush_q5 got %0d want 5", bus.count); end
    tsre_drv = 1'b1;
    t = 0;
    while (bus.wrn !== 1'b0 && t < 20) begin step(1); t++; end
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL flush_clear got count=%0d empty=%b busy=%b want 0 1 1", bus.count, bus.empty, bus.busy);
    end
    step(40);
    checks++; if (fall_data.size() != base + 1) begin errors++; $display("FAIL flush_strobes got %0d want 1", fall_data.size() - base); end
    if (fall_data.size() >= base + 1) begin
      checks++; if (fall_data[base] !== 8'h61) begin errors++; $display("FAIL flush_byte got %h want 61", fall_data[base]); end
    end
    checks++; if (bus.wrn !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL flush_end got wrn=%b busy=%b ovf=%b want 1 0 0", bus.wrn, bus.busy, bus.overflow);
    end
  endtask
`endif

  initial begin
    bus.push = 1'b0;
    bus.push_data = 8'h00;
`ifdef UART_TX_FLUSH_EN
    bus.flush = 1'b0;
`endif
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
`ifdef UART_TX_FLUSH_EN
    test_flush;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
